// File: rtl/glitchy.sv
// Four-state Moore read-cycle controller: go -> rd (with ws wait states) -> one-cycle ds.
// Outputs are an unregistered decode of the state register.
module glitchy (
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    input  logic ws,
    output logic rd,
    output logic ds
);

    localparam int unsigned STATE_W = 2;

    // Every code is a valid state, and each legal transition flips only one bit.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        DLY  = 2'b11,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and pure state decode of rd/ds.
    always_comb begin
        next_state = state;
        rd         = 1'b0;
        ds         = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    next_state = READ;
                end
            end
            READ: begin
                rd         = 1'b1;
                next_state = DLY;
            end
            DLY: begin
                rd         = 1'b1;
                next_state = ws ? READ : DONE;
            end
            DONE: begin
                ds         = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_glitchy.sv
// Randomised and directed bench for glitchy, checked against a read-cycle position model.
`timescale 1ns/1ps
module tb_glitchy;

    logic clk;
    logic reset_n;
    logic go;
    logic ws;
    logic rd;
    logic ds;

    int n_checks = 0;
    int n_pass   = 0;
    int ds_seen  = 0;
    int rd_seen  = 0;

    // Model: 0 = idle, -1 = done cycle, k > 0 = k-th cycle inside the read strobe.
    // Odd k: address cycle (ws ignored); even k: ws decides extend or finish.
    int pos = 0;

    glitchy dut (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .ws      (ws),
        .rd      (rd),
        .ds      (ds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare mid-cycle.
    task automatic cyc(input logic g, input logic w, input logic r);
        go      = g;
        ws      = w;
        reset_n = r;
        @(posedge clk);
        if (!r)            pos = 0;
        else if (pos == 0) pos = g ? 1 : 0;
        else if (pos < 0)  pos = 0;
        else if (pos % 2 == 1) pos = pos + 1;
        else               pos = w ? pos + 1 : -1;
        @(negedge clk);
        check("rd", 32'(rd), 32'(pos > 0));
        check("ds", 32'(ds), 32'(pos == -1));
        if (ds === 1'b1) ds_seen++;
        if (rd === 1'b1) rd_seen++;
    endtask

    initial begin
        go      = 1'b1;
        ws      = 1'b1;
        reset_n = 1'b0;

        // Reset with go and ws high keeps the block idle.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_ds", 32'(ds), 32'd0);

        // Minimum read: rd two cycles, ds one cycle.
        rd_seen = 0; ds_seen = 0;
        cyc(1'b1, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        check("basic_rd_width", 32'(rd_seen), 32'd2);
        check("basic_ds_count", 32'(ds_seen), 32'd1);

        // ws held high: rd stays high, no ds.
        ds_seen = 0;
        cyc(1'b1, 1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b1, 1'b1);
        check("ws_held_rd", 32'(rd), 32'd1);
        check("ws_held_ds", 32'(ds_seen), 32'd0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);

        // Exactly one wait state: rd four cycles, then one ds.
        rd_seen = 0; ds_seen = 0;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        check("one_wait_rd_width", 32'(rd_seen), 32'd4);
        check("one_wait_ds_count", 32'(ds_seen), 32'd1);

        // go held high: a ds every four edges.
        ds_seen = 0;
        repeat (12) cyc(1'b1, 1'b0, 1'b1);
        check("b2b_ds_count", 32'(ds_seen), 32'd3);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);

        // Reset while in the wait-decision cycle aborts without ds.
        ds_seen = 0;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("pre_abort_rd", 32'(rd), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        check("abort_ds_count", 32'(ds_seen), 32'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 31) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
